// File: rtl/arb_requester_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_requester_pkg : shared types and width helpers for requester   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package arb_requester_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        YIELD = 2'd2
    } state_t;

    // Bits needed to hold any value 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_req_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_req_fifo : synchronous FIFO, head word always visible on rdata |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module arb_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DATA_W-1:0]  r_mem_q [DEPTH];
    logic [c_ptr_w-1:0] r_wptr_q, w_wptr_d;
    logic [c_ptr_w-1:0] r_rptr_q, w_rptr_d;
    logic [c_cnt_w-1:0] r_count_q, w_count_d;
    logic               w_push, w_pop;

    assign full   = (r_count_q == c_cnt_w'(DEPTH));
    assign empty  = (r_count_q == '0);
    // A full FIFO refuses the write even when a read frees a slot this cycle.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem_q[r_rptr_q];
    assign count  = r_count_q;

    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (w_push) w_wptr_d = r_wptr_q + c_ptr_w'(1);
        if (w_pop)  w_rptr_d = r_rptr_q + c_ptr_w'(1);
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_cnt_w'(1);
            2'b01:   w_count_d = r_count_q - c_cnt_w'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem_q[r_wptr_q] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/arb_requester.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_requester : buffered requester for one round-robin arbiter port|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module arb_requester
    import arb_requester_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4,
    parameter int MAX_HOLD   = 4,
    parameter int STARVE_LIM = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              starve
);

    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_hold_w = cnt_width(MAX_HOLD);
    localparam int c_wait_w = cnt_width(STARVE_LIM);

    state_t              r_state_q, w_state_d;
    logic [c_hold_w-1:0] r_hold_q, w_hold_d, w_hold_inc;
    logic [c_wait_w-1:0] r_wait_q, w_wait_d;
    logic                r_starve_q, w_starve_d;
    logic [c_cnt_w-1:0]  w_count, w_count_post;
    logic                w_full, w_empty, w_push, w_pop;

    arb_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (bus_data),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign in_ready  = ~w_full;
    assign w_push    = in_valid & in_ready;
    // req comes from the state register only, so no loop forms through gnt.
    assign req       = (r_state_q == REQ);
    assign bus_valid = req & gnt;
    assign w_pop     = bus_valid;
    assign starve    = r_starve_q;

    assign w_count_post = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_hold_inc   = r_hold_q + c_hold_w'(1);

    always_comb begin
        w_state_d = r_state_q;
        w_hold_d  = '0;
        w_wait_d  = '0;
        case (r_state_q)
            IDLE: begin
                if (w_push | ~w_empty) w_state_d = REQ;
            end
            REQ: begin
                if (gnt) begin
                    w_hold_d = w_hold_inc;
                    if (w_count_post == '0) begin
                        w_state_d = IDLE;
                        w_hold_d  = '0;
                    end else if (w_hold_inc == c_hold_w'(MAX_HOLD)) begin
                        w_state_d = YIELD;
                        w_hold_d  = '0;
                    end
                end else begin
                    w_hold_d = r_hold_q;
                    w_wait_d = (r_wait_q == c_wait_w'(STARVE_LIM)) ? r_wait_q
                                                                    : r_wait_q + c_wait_w'(1);
                end
            end
            YIELD: begin
                w_state_d = (w_count_post != '0) ? REQ : IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        w_starve_d = (w_wait_d == c_wait_w'(STARVE_LIM));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_hold_q   <= '0;
            r_wait_q   <= '0;
            r_starve_q <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_hold_q   <= w_hold_d;
            r_wait_q   <= w_wait_d;
            r_starve_q <= w_starve_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_arb_requester : scenario and randomized checks for arb_requester|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_arb_requester;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 4;
    localparam int MAX_HOLD   = 4;
    localparam int STARVE_LIM = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              req;
    logic              gnt;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              starve;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arb_requester #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .MAX_HOLD   (MAX_HOLD),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .starve    (starve)
    );

    // Behavioural model: a word queue plus the requester's rules in plain terms.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] dut_seen[$];
    bit                m_req;
    bit                m_yield;
    int                m_run;
    int                m_wait;

    function automatic void model_reset();
        m_q.delete();
        m_req   = 1'b0;
        m_yield = 1'b0;
        m_run   = 0;
        m_wait  = 0;
    endfunction

    function automatic void model_edge(bit iv, logic [DATA_W-1:0] d, bit g);
        bit do_push;
        bit do_pop;
        do_push = iv && (m_q.size() < DEPTH);
        do_pop  = m_req && g;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(d);
        if (m_req) begin
            if (g) begin
                m_run++;
                m_wait = 0;
                if (m_q.size() == 0) m_req = 1'b0;
                else if (m_run == MAX_HOLD) begin
                    m_req   = 1'b0;
                    m_yield = 1'b1;
                end
            end else if (m_wait < STARVE_LIM) begin
                m_wait++;
            end
        end else if (m_yield) begin
            m_yield = 1'b0;
            m_req   = (m_q.size() != 0);
            m_run   = 0;
        end else begin
            m_req = (m_q.size() != 0);
            m_run = 0;
        end
        if (!m_req) m_wait = 0;
    endfunction

    task automatic drive(input bit iv, input logic [DATA_W-1:0] d, input bit g);
        in_valid = iv;
        in_data  = d;
        gnt      = g;
        #1;
    endtask

    task automatic tick();
        if (bus_valid === 1'b1) dut_seen.push_back(bus_data);
        model_edge(in_valid, in_data, gnt);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        drive(1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dut_seen.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        drive(1'b1, 8'h3C, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (starve !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b expected 0", starve); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 8'hA5, 1'b1);
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_c0_req: got %b expected 0", req); end
        tick();
        drive(1'b0, '0, 1'b1);
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_c1_req: got %b expected 1", req); end
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL single_c1_valid: got %b expected 1", bus_valid); end
        checks++; if (bus_data !== 8'hA5) begin errors++; $display("FAIL single_c1_data: got %h expected a5", bus_data); end
        tick();
        for (int c = 2; c < 4; c++) begin
            drive(1'b0, '0, 1'b1);
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_c%0d_req: got %b expected 0", c, req); end
            tick();
        end
    endtask

    task automatic test_yield();
        logic [9:0] got_req;
        logic [9:0] exp_req;
        bit         ok;
        int         n;
        do_reset();
        exp_req = 10'b0011011110;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            bit iv;
            iv = (n < 6) && (in_ready === 1'b1);
            drive(iv, 8'(8'h10 + n), 1'b1);
            got_req[c] = req;
            checks++;
            if (bus_valid === 1'b1 && (m_q.size() == 0 || bus_data !== m_q[0])) begin
                errors++; $display("FAIL yield_data_c%0d: got %h expected model head", c, bus_data);
            end
            if (iv) n++;
            tick();
        end
        checks++; if (got_req !== exp_req) begin errors++; $display("FAIL yield_req_pattern: got %b expected %b", got_req, exp_req); end
        ok = (dut_seen.size() == 6);
        for (int i = 0; i < dut_seen.size() && ok; i++) if (dut_seen[i] !== 8'(8'h10 + i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL yield_order: got %0d words, expected 10..15 in order", dut_seen.size()); end
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0);
            tick();
        end
        drive(1'b1, 8'hFF, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        tick();
        drive(1'b0, '0, 1'b1);
        checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h40) begin
            errors++; $display("FAIL full_first_pop: got valid=%b data=%h expected valid=1 data=40", bus_valid, bus_data);
        end
        tick();
        drive(1'b0, '0, 1'b0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop: got %b expected 1", in_ready); end
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        ok = (dut_seen.size() == 4);
        for (int i = 0; i < dut_seen.size() && ok; i++) if (dut_seen[i] !== 8'(8'h40 + i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL full_order: got %0d words, expected 40..43 with no ff", dut_seen.size()); end
    endtask

    task automatic test_starve();
        do_reset();
        drive(1'b1, 8'h77, 1'b0);
        tick();
        for (int k = 1; k <= STARVE_LIM; k++) begin
            drive(1'b0, '0, 1'b0);
            checks++; if (starve !== 1'b0 || req !== 1'b1) begin
                errors++; $display("FAIL starve_early_%0d: got starve=%b req=%b expected starve=0 req=1", k, starve, req);
            end
            tick();
        end
        drive(1'b0, '0, 1'b1);
        checks++; if (starve !== 1'b1) begin errors++; $display("FAIL starve_raised: got %b expected 1", starve); end
        checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h77) begin
            errors++; $display("FAIL starve_grant: got valid=%b data=%h expected valid=1 data=77", bus_valid, bus_data);
        end
        tick();
        drive(1'b0, '0, 1'b0);
        checks++; if (starve !== 1'b0) begin errors++; $display("FAIL starve_cleared: got %b expected 0", starve); end
        tick();
    endtask

    task automatic test_push_pop();
        bit ok;
        do_reset();
        drive(1'b1, 8'h31, 1'b0); tick();
        drive(1'b1, 8'h32, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b1);
        checks++; if (dut.w_count !== 3'd2) begin errors++; $display("FAIL pp_count_before: got %0d expected 2", dut.w_count); end
        checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h31) begin
            errors++; $display("FAIL pp_pop: got valid=%b data=%h expected valid=1 data=31", bus_valid, bus_data);
        end
        tick();
        drive(1'b0, '0, 1'b0);
        checks++; if (dut.w_count !== 3'd2) begin errors++; $display("FAIL pp_count_after: got %0d expected 2", dut.w_count); end
        tick();
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, '0, 1'b1);
            tick();
        end
        ok = (dut_seen.size() == 3);
        for (int i = 0; i < dut_seen.size() && ok; i++) if (dut_seen[i] !== 8'(8'h31 + i)) ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL pp_order: got %0d words, expected 31,32,33", dut_seen.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b0);
            tick();
        end
        for (int c = 0; c < STARVE_LIM + 1; c++) begin
            drive(1'b0, '0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1);
        checks++; if (starve !== 1'b1 || bus_valid !== 1'b1) begin
            errors++; $display("FAIL rmid_pre: got starve=%b valid=%b expected 1 1", starve, bus_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (req !== 1'b0 || bus_valid !== 1'b0 || starve !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_async: got req=%b valid=%b starve=%b ready=%b expected 0 0 0 1",
                               req, bus_valid, starve, in_ready);
        end
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        dut_seen.delete();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, '0, 1'b1);
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL rmid_idle_c%0d: got req=%b expected 0", c, req); end
            tick();
        end
    endtask

    task automatic test_random();
        int gnt_pct;
        do_reset();
        for (int c = 0; c < 900; c++) begin
            case ((c / 100) % 3)
                0:       gnt_pct = 90;
                1:       gnt_pct = 50;
                default: gnt_pct = 3;
            endcase
            drive($urandom_range(99) < 60, 8'($urandom), $urandom_range(99) < gnt_pct);
            checks++; if (req !== m_req) begin errors++; $display("FAIL rnd_req c%0d: got %b expected %b", c, req, m_req); end
            checks++; if (in_ready !== (m_q.size() < DEPTH)) begin
                errors++; $display("FAIL rnd_in_ready c%0d: got %b expected %b", c, in_ready, m_q.size() < DEPTH);
            end
            checks++; if (bus_valid !== (m_req && gnt)) begin
                errors++; $display("FAIL rnd_bus_valid c%0d: got %b expected %b", c, bus_valid, m_req && gnt);
            end
            checks++; if (starve !== (m_wait == STARVE_LIM)) begin
                errors++; $display("FAIL rnd_starve c%0d: got %b expected %b", c, starve, m_wait == STARVE_LIM);
            end
            if (m_req && gnt && m_q.size() != 0) begin
                checks++; if (bus_data !== m_q[0]) begin
                    errors++; $display("FAIL rnd_bus_data c%0d: got %h expected %h", c, bus_data, m_q[0]);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        gnt      = 1'b0;
        test_reset();
        test_single();
        test_yield();
        test_full();
        test_starve();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arb_requester.md
Name: arb_requester

Overview:
Requester-side client for the two-input round-robin arbiter. It buffers upstream words in a small FIFO and presents a registered req to one arbiter port. It consumes the arbiter's combinational gnt, transferring one word onto the shared bus per granted cycle. It also yields voluntarily after a bounded number of consecutive grants, and flags starvation when req goes unanswered for too long.

Parameters:
DATA_W, 8, width of buffered and transferred word
DEPTH, 4, FIFO entries; power of 2, at least 2
MAX_HOLD, 4, maximum consecutive granted cycles before a forced one-cycle yield; at least 1
STARVE_LIM, 15, count of non-granted req cycles that raises starve; at least 1

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  upstream word valid
in_data  in  DATA_W  upstream word
in_ready  out  1  FIFO can accept; equals (count < DEPTH)
req  out  1  request to arbiter; registered
gnt  in  1  grant from arbiter; combinational on arbiter side
bus_valid  out  1  transfer this cycle; equals req & gnt
bus_data  out  DATA_W  FIFO head; don't-care when bus_valid=0
starve  out  1  registered starvation flag

Behaviour:
- Interface decision: reset rst, asynchronous, active-high; clock clk.
- Reset values: state IDLE, req=0, FIFO empty (count=0), hold_cnt=0, wait_cnt=0, starve=0. Derived outputs during reset: in_ready=1, bus_valid=0.
- Asserting rst mid-operation discards FIFO contents and drops req at once (asynchronous).
- req must never depend combinationally on gnt; it is driven by registered state only. This avoids a loop through the arbiter.
- Push: in_valid & in_ready at posedge. A full FIFO refuses the push even if a pop occurs in the same cycle; there is no pass-through when full.
- Pop: bus_valid at posedge. A push and a pop in the same cycle leave count unchanged, and FIFO order is preserved.
- Pointers wrap modulo DEPTH. count is clog2(DEPTH)+1 bits wide.
- FSM states are IDLE (req=0), REQ (req=1) and YIELD (req=0).
- IDLE -> REQ when count != 0 at the edge. The first word is therefore requested in the cycle after it was pushed.
- On entering REQ, hold_cnt and wait_cnt are cleared.
- REQ with gnt=1: pop one word, hold_cnt+1, wait_cnt cleared. Next state is decided on the post-edge count:
  - post-edge count == 0 -> IDLE;
  - otherwise, hold_cnt reaches MAX_HOLD on this grant -> YIELD;
  - otherwise stay in REQ.
- REQ with gnt=0: stay in REQ. wait_cnt+1, saturating at STARVE_LIM.
- YIELD always lasts exactly one cycle, then -> REQ if count != 0, else -> IDLE.
- starve is registered and equals (wait_cnt == STARVE_LIM). It stays high until a grant clears wait_cnt. It falls the cycle after the first grant, or the cycle after leaving REQ.
- wait_cnt is cleared in IDLE and YIELD. The YIELD cycle does not count toward starvation.
- Latency: push to first bus_valid is 1 cycle minimum, assuming the arbiter grants immediately.

Decomposition:
- Package arb_requester_pkg:
  - FSM state enum: IDLE=2'd0, REQ=2'd1, YIELD=2'd2;
  - localparam helpers for counter widths, each clog2(limit+1).
- Sub-module arb_req_fifo, a synchronous FIFO:
  - inputs: clk, rst, push, pop, wdata;
  - outputs: rdata (head), count, full, empty.
- Top level holds the FSM, hold_cnt, wait_cnt and starve.

Test Plan:
- Reset, push 0xA5 at cycle 0, gnt tied 1 -> req=1 and bus_valid=1 with bus_data=0xA5 in cycle 1; req=0 from cycle 2; state IDLE.
- gnt tied 1; push D0..D5 = 0x10..0x15 as fast as in_ready allows -> bus order 0x10..0x15. Grants occur on 4 consecutive cycles, then req=0 for exactly one cycle, then the remaining 2 words transfer.
- gnt=0; push 4 words -> in_ready=0 after 4th push; a 5th in_valid with 0xFF is dropped. Then one gnt cycle -> in_ready=1 next cycle, and 0xFF never appears on the bus.
- req=1 with gnt=0 for 15 cycles -> starve=1 after the 15th edge. gnt=1 for one cycle -> starve=0 the following cycle.
- At count=2, push and pop in the same cycle -> count stays 2; subsequent bus_data order matches push order.
- Assert rst while in REQ with 3 words buffered -> req, bus_valid and starve go to 0 immediately, in_ready=1. After release, no req without a new push.
